// File: rtl/mem_access_ctrl.sv
// Data-memory sequencer: one bus transaction per load/store, stalls the PC.
// Optional BUSY watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [5:0]  alu_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  op_q, op_nx;
  logic [1:0]  lo_q, lo_nx;
  logic        req_nx, we_nx, fault_nx;
  logic [31:0] addr_nx, wdata_nx, ld_nx;
  logic [3:0]  strb_nx;

  logic        mem_op, bad, tmo;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c, ext_c, shf_c;
  logic [15:0] half_c;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_nx;
  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign mem_op = mem_write | mem_to_reg;
  assign stall  = ((state == IDLE) & mem_op) | (state == BUSY);

  // Decode legality, strobes and lane-replicated write data.
  always_comb begin
    bad     = 1'b0;
    strb_c  = 4'b0000;
    wdata_c = 32'd0;
    if (mem_write && mem_to_reg) begin
      bad = 1'b1;
    end else if (mem_to_reg) begin
      case (alu_op)
        OP_LB, OP_LBU: bad = 1'b0;
        OP_LH:         bad = addr[0];
        OP_LW:         bad = |addr[1:0];
        default:       bad = 1'b1;
      endcase
    end else begin
      case (alu_op)
        OP_SB: begin
          strb_c  = 4'b0001 << addr[1:0];
          wdata_c = {4{store_data[7:0]}};
        end
        OP_SH: begin
          strb_c  = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{store_data[15:0]}};
          bad     = addr[0];
        end
        OP_SW: begin
          strb_c  = 4'b1111;
          wdata_c = store_data;
          bad     = |addr[1:0];
        end
        default: bad = 1'b1;
      endcase
    end
  end

  // Lane select and extension of the returned read word.
  always_comb begin
    shf_c  = bus_rdata >> {lo_q, 3'b000};
    half_c = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext_c  = 32'd0;
    case (op_q)
      OP_LB:   ext_c = {{24{shf_c[7]}}, shf_c[7:0]};
      OP_LBU:  ext_c = {24'd0, shf_c[7:0]};
      OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
      OP_LW:   ext_c = bus_rdata;
      default: ext_c = 32'd0;
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    lo_nx    = lo_q;
    req_nx   = bus_req;
    we_nx    = bus_we;
    addr_nx  = bus_addr;
    wdata_nx = bus_wdata;
    strb_nx  = bus_wstrb;
    ld_nx    = load_data;
    fault_nx = fault;
`ifdef MEM_TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          op_nx = alu_op;
          lo_nx = addr[1:0];
          if (bad) begin
            fault_nx = 1'b1;
            ld_nx    = 32'd0;
            state_nx = DONE;
          end else begin
            req_nx   = 1'b1;
            we_nx    = mem_write;
            addr_nx  = {addr[31:2], 2'b00};
            wdata_nx = wdata_c;
            strb_nx  = strb_c;
`ifdef MEM_TIMEOUT_EN
            cnt_nx   = '0;
`endif
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ack || tmo) begin
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          addr_nx  = 32'd0;
          wdata_nx = 32'd0;
          strb_nx  = 4'b0000;
          fault_nx = ~bus_ack;
          ld_nx    = (bus_ack && !bus_we) ? ext_c : 32'd0;
          state_nx = DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_nx = cnt + 1'b1;
`endif
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      lo_q      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      load_data <= '0;
      fault     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      lo_q      <= lo_nx;
      bus_req   <= req_nx;
      bus_we    <= we_nx;
      bus_addr  <= addr_nx;
      bus_wdata <= wdata_nx;
      bus_wstrb <= strb_nx;
      load_data <= ld_nx;
      fault     <= fault_nx;
`ifdef MEM_TIMEOUT_EN
      cnt       <= cnt_nx;
`endif
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory sequencer for the single-cycle RV32 core. It sits between the control decoder/ALU and the data-memory bus. For every load or store it stalls the PC, issues one word-aligned bus transaction with byte strobes, and returns a sign- or zero-extended load value to writeback. Misaligned and unsupported accesses are flagged as faults.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of BUSY cycles before an abort. Only used when `MEM_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  decoder memWrite.
- `mem_to_reg`  in  1  decoder memToReg, marks a load.
- `alu_op`  in  6  decoder aluOP. Loads: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU. Stores: 15 SB, 16 SH, 17 SW.
- `addr`  in  32  effective address (ALU result).
- `store_data`  in  32  rs2 value.
- `stall`  out  1  holds the PC and register-file write.
- `load_data`  out  32  extended load result; valid while DONE.
- `fault`  out  1  valid in DONE; set for misaligned, unsupported or timed-out access.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{addr[31:2], 2'b00}`.
- `bus_wdata`  out  32  replicated store data.
- `bus_wstrb`  out  4  byte enables; 0 for reads.
- `bus_ack`  in  1  one-cycle completion; `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  32  read word.

## Operation
- `mem_op` = `mem_write | mem_to_reg`.
- FSM states:
  - IDLE:
    - If `mem_op` is high: latch `alu_op`, `addr[1:0]`, `store_data` and the bus fields.
    - Go to DONE with `fault`=1 in any of these cases: both `mem_write` and `mem_to_reg` are high; `alu_op` is not a legal code for the direction; LD; LH/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0.
    - Otherwise go to BUSY.
  - BUSY: `bus_req`=1. On `bus_ack`, register `bus_rdata` and go to DONE with `fault`=0.
  - DONE: always go to IDLE.
- Strobes and write data:
  - SB: `wstrb` = `4'b0001 << addr[1:0]`; `wdata` = `{4{store_data[7:0]}}`.
  - SH: `wstrb` = `0011` if `addr[1]`=0, else `1100`; `wdata` = `{2{store_data[15:0]}}`.
  - SW: `wstrb` = `1111`; `wdata` = `store_data`.
- Load extraction:
  - Select the byte by `addr[1:0]` or the halfword by `addr[1]`.
  - LB and LH sign-extend; LBU zero-extends; LW passes the word through.
- On fault: `load_data` = 0 and no bus transaction is issued.
- `bus_ack` is ignored in IDLE and DONE.

## Timing
- Reset (asynchronous, immediate): state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `load_data`, `fault` all 0.
- `stall` is combinational: `(IDLE & mem_op) | BUSY`.
- Bus outputs and `load_data`/`fault` are registered.
- Minimum access, with `bus_ack` in the first BUSY cycle:
  - cycle 0: IDLE, `stall`=1.
  - cycle 1: BUSY, `bus_req`=1, ack.
  - cycle 2: DONE, `stall`=0; the core writes back and advances.
  - cycle 3: IDLE.
- Each cycle of ack delay adds one BUSY cycle.
- Fault path: IDLE → DONE in one cycle, `bus_req` never asserted.
- `bus_req` and all bus fields are held stable throughout BUSY and fall to 0 on the cycle after ack.
- Inputs are sampled only in IDLE; changes during BUSY/DONE are ignored.
- Reset during BUSY drops `bus_req` asynchronously. A later ack is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A BUSY cycle counter (width `$clog2(TIMEOUT_CYCLES+1)`) clears on entry to BUSY.
  - If `TIMEOUT_CYCLES` BUSY cycles pass without ack, go to DONE with `fault`=1, `load_data`=0, and drop `bus_req`.
  - An ack in the final BUSY cycle wins over the timeout.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely for `bus_ack`.

## Test plan
- SW, `addr`=0x1000, `store_data`=0xDEADBEEF, ack in first BUSY cycle → `bus_addr`=0x1000, `wstrb`=1111, `wdata`=0xDEADBEEF, `stall` high for exactly 2 cycles, `fault`=0.
- SB, `addr`=0x2002, `store_data`=0x12345678 → `wstrb`=0100, `wdata`=0x78787878, `bus_addr`=0x2000.
- LB, `addr`=0x1003, `rdata`=0x80FF0011, ack after 3 BUSY cycles → `load_data`=0xFFFFFF80 in DONE. The same access as LBU → 0x00000080. `stall` high for 4 cycles.
- LH, `addr`=0x1001 → no `bus_req`, DONE the next cycle with `fault`=1 and `load_data`=0. LD (`alu_op`=3) → same response.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, LW with no ack → `bus_req` for 16 cycles, then DONE with `fault`=1 and `stall` released.
- LW in BUSY, `rst_n` asserted mid-cycle → `bus_req`=0 immediately, state IDLE, ack after reset release ignored.
